// File: rtl/ir_flag_unit.sv
// Instruction register and C/Z flag unit sitting beside the multicycle controller.
// It decodes IR fields, gates conditional writebacks and updates the flags at writeback.
module ir_flag_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] memdata,
  input  logic             irwrite,
  input  logic             regwrite_in,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             alu_carry,
  output logic [3:0]       op,
  output logic [1:0]       cz,
  output logic [2:0]       ra,
  output logic [2:0]       rb,
  output logic [2:0]       rc,
  output logic [WIDTH-1:0] imm6_se,
  output logic [WIDTH-1:0] imm9_se,
  output logic             regwrite,
  output logic             cond_ok,
  output logic             c_flag,
  output logic             z_flag,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_ADI  = 4'b0001,
    OP_NAND = 4'b0010,
    OP_LW   = 4'b0100
  } op_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] ir_q, ir_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             wb_zero;

  // Field decode is purely combinational from the held instruction.
  assign op      = ir_q[15:12];
  assign ra      = ir_q[11:9];
  assign rb      = ir_q[8:6];
  assign rc      = ir_q[5:3];
  assign cz      = ir_q[1:0];
  assign imm6_se = {{(WIDTH-6){ir_q[5]}}, ir_q[5:0]};
  assign imm9_se = {{(WIDTH-9){ir_q[8]}}, ir_q[8:0]};

  assign c_flag  = c_q;
  assign z_flag  = z_q;
  assign retired = retired_q;
  assign wb_zero = (wb_data == '0);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cond_ok = 1'b1;
    case (op_e'(op))
      OP_ADD: begin
        case (cz)
          2'b10:   cond_ok = c_q;
          2'b01:   cond_ok = z_q;
          default: cond_ok = 1'b1;
        endcase
      end
      OP_NAND: begin
        case (cz)
          2'b10:   cond_ok = c_q;
          2'b01:   cond_ok = z_q;
          2'b11:   cond_ok = 1'b0;
          default: cond_ok = 1'b1;
        endcase
      end
      default: cond_ok = 1'b1;
    endcase
  end

  // Reset term keeps the write enable low throughout an asynchronous reset.
  assign regwrite = regwrite_in & cond_ok & reset;

  // Flag next-state decodes the IR held at this edge, not the one being loaded.
  always_comb begin
    c_d = c_q;
    z_d = z_q;
    if (regwrite) begin
      case (op_e'(op))
        OP_ADD, OP_ADI: begin
          c_d = alu_carry;
          z_d = wb_zero;
        end
        OP_NAND, OP_LW: begin
          z_d = wb_zero;
        end
        default: begin
          c_d = c_q;
          z_d = z_q;
        end
      endcase
    end
  end

  always_comb begin
    ir_d      = ir_q;
    retired_d = retired_q;
    if (irwrite) begin
      ir_d      = memdata;
      retired_d = retired_q + CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, which is what makes same-edge IR load and
  // flag update see the old instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q      <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      retired_q <= '0;
    end else begin
      ir_q      <= ir_d;
      c_q       <= c_d;
      z_q       <= z_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_ir_flag_unit.sv
// Directed bench for ir_flag_unit: decode, conditional gating, flag updates,
// same-edge load/writeback, counter wrap and asynchronous reset.
module tb_ir_flag_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] memdata;
  logic        irwrite;
  logic        regwrite_in;
  logic [15:0] wb_data;
  logic        alu_carry;
  logic [3:0]  op;
  logic [1:0]  cz;
  logic [2:0]  ra, rb, rc;
  logic [15:0] imm6_se, imm9_se;
  logic        regwrite, cond_ok, c_flag, z_flag;
  logic [15:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] I_ADI  = 16'h1772; // 0001_011_101_110010
  localparam logic [15:0] I_ADD  = 16'h04E0; // 0000_010_011_100_000
  localparam logic [15:0] I_ADC  = 16'h0242; // 0000_001_001_000_010
  localparam logic [15:0] I_NDZ  = 16'h2299; // 0010_001_010_011_001
  localparam logic [15:0] I_ND11 = 16'h229B; // 0010_001_010_011_011
  localparam logic [15:0] I_LW   = 16'h4B87; // 0100_101_110_000111

  ir_flag_unit #(.WIDTH(16), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .memdata    (memdata),
    .irwrite    (irwrite),
    .regwrite_in(regwrite_in),
    .wb_data    (wb_data),
    .alu_carry  (alu_carry),
    .op         (op),
    .cz         (cz),
    .ra         (ra),
    .rb         (rb),
    .rc         (rc),
    .imm6_se    (imm6_se),
    .imm9_se    (imm9_se),
    .regwrite   (regwrite),
    .cond_ok    (cond_ok),
    .c_flag     (c_flag),
    .z_flag     (z_flag),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] instr);
    memdata = instr;
    irwrite = 1'b1;
    tick();
    irwrite = 1'b0;
  endtask

  task automatic writeback(input logic [15:0] data, input logic carry);
    regwrite_in = 1'b1;
    wb_data     = data;
    alu_carry   = carry;
    tick();
    regwrite_in = 1'b0;
  endtask

  initial begin
    // Reset held with aggressive stimulus on every input.
    reset       = 1'b0;
    memdata     = 16'hFFFF;
    irwrite     = 1'b1;
    regwrite_in = 1'b1;
    wb_data     = 16'h0000;
    alu_carry   = 1'b1;
    #1;
    check("rst_regwrite_t0", regwrite, 1'b0);
    tick(); tick(); tick();
    check("rst_op",       op,       4'h0);
    check("rst_cz",       cz,       2'b00);
    check("rst_imm9",     imm9_se,  16'h0000);
    check("rst_regwrite", regwrite, 1'b0);
    check("rst_c",        c_flag,   1'b0);
    check("rst_z",        z_flag,   1'b0);
    check("rst_retired",  retired,  16'h0000);

    // Release reset with the controller idle.
    irwrite     = 1'b0;
    regwrite_in = 1'b0;
    alu_carry   = 1'b0;
    reset       = 1'b1;
    tick();
    check("idle_retired", retired, 16'h0000);

    // ADI field decode.
    load(I_ADI);
    check("adi_op",      op,      4'h1);
    check("adi_ra",      ra,      3'd3);
    check("adi_rb",      rb,      3'd5);
    check("adi_rc",      rc,      3'd6);
    check("adi_cz",      cz,      2'b10);
    check("adi_imm6",    imm6_se, 16'hFFF2);
    check("adi_imm9",    imm9_se, 16'hFF72);
    check("adi_cond",    cond_ok, 1'b1);
    check("adi_retired", retired, 16'd1);
    tick();
    check("ir_hold_op",  op,      4'h1);
    check("ir_hold_ret", retired, 16'd1);

    // ADD sets C and Z.
    load(I_ADD);
    regwrite_in = 1'b1;
    #1;
    check("add_regwrite", regwrite, 1'b1);
    writeback(16'h0000, 1'b1);
    check("add_c", c_flag, 1'b1);
    check("add_z", z_flag, 1'b1);

    // ADC taken with C=1 (no writeback edge issued).
    load(I_ADC);
    regwrite_in = 1'b1;
    #1;
    check("adc_taken_rw",   regwrite, 1'b1);
    check("adc_taken_cond", cond_ok,  1'b1);
    regwrite_in = 1'b0;

    // Clear C through ADD, then ADC must be suppressed.
    load(I_ADD);
    writeback(16'h0005, 1'b0);
    check("add2_c", c_flag, 1'b0);
    check("add2_z", z_flag, 1'b0);
    load(I_ADC);
    regwrite_in = 1'b1;
    #1;
    check("adc_skip_rw",   regwrite, 1'b0);
    check("adc_skip_cond", cond_ok,  1'b0);
    writeback(16'h0000, 1'b1);
    check("adc_skip_c", c_flag, 1'b0);
    check("adc_skip_z", z_flag, 1'b0);

    // NDZ suppressed with Z=0.
    load(I_NDZ);
    regwrite_in = 1'b1;
    #1;
    check("ndz_skip_rw", regwrite, 1'b0);
    regwrite_in = 1'b0;

    // Set C=1, Z=1, then NDZ taken: Z from result, C holds.
    load(I_ADD);
    writeback(16'h0000, 1'b1);
    load(I_NDZ);
    regwrite_in = 1'b1;
    #1;
    check("ndz_taken_rw", regwrite, 1'b1);
    writeback(16'h0004, 1'b0);
    check("ndz_z", z_flag, 1'b0);
    check("ndz_c", c_flag, 1'b1);

    // Reserved NAND cz=11 never writes.
    load(I_ND11);
    regwrite_in = 1'b1;
    #1;
    check("nd11_rw",   regwrite, 1'b0);
    check("nd11_cond", cond_ok,  1'b0);
    regwrite_in = 1'b0;
    check("pre_wrap_ret", retired, 16'd9);

    // Bring the counter to 16'hFFFF with ADD held in the IR.
    load(I_ADD);
    memdata = I_ADD;
    irwrite = 1'b1;
    for (int i = 0; i < 65525; i++) @(posedge clk);
    #1;
    irwrite = 1'b0;
    check("preset_ret", retired, 16'hFFFF);
    check("preset_op",  op,      4'h0);

    // Same edge: load LW while ADD writes back; flags follow ADD, counter wraps.
    memdata     = I_LW;
    irwrite     = 1'b1;
    regwrite_in = 1'b1;
    wb_data     = 16'h0000;
    alu_carry   = 1'b0;
    #1;
    check("same_rw", regwrite, 1'b1);
    tick();
    irwrite     = 1'b0;
    regwrite_in = 1'b0;
    check("same_z",   z_flag,  1'b1);
    check("same_c",   c_flag,  1'b0);
    check("same_op",  op,      4'h4);
    check("same_ret", retired, 16'h0000);

    // LW writeback: Z from result, C holds even with carry asserted.
    writeback(16'h0007, 1'b1);
    check("lw_z", z_flag, 1'b0);
    check("lw_c", c_flag, 1'b0);
    writeback(16'h0000, 1'b1);
    check("lw_z2", z_flag, 1'b1);
    check("lw_c2", c_flag, 1'b0);

    // Asynchronous reset mid-instruction, away from any clock edge.
    regwrite_in = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("arst_rw",  regwrite, 1'b0);
    check("arst_op",  op,       4'h0);
    check("arst_z",   z_flag,   1'b0);
    check("arst_ret", retired,  16'h0000);
    regwrite_in = 1'b0;
    tick();
    reset = 1'b1;
    load(I_ADI);
    check("post_rst_op",  op,      4'h1);
    check("post_rst_ret", retired, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_flag_unit.md
Name: ir_flag_unit

Overview:
- Datapath-side stage directly upstream and downstream of the multicycle controller.
- Latches the 16-bit instruction fetched from memory and supplies the controller's op and cz fields plus the register and immediate fields the datapath needs.
- Holds the architectural carry (C) and zero (Z) flags.
- Gates the controller's regwrite for conditional ALU instructions (ADC, ADZ, NDC, NDZ) and updates the flags at writeback.

Parameters:
- WIDTH, 16, instruction and data width.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- memdata  in  WIDTH  memory read data, the instruction source.
- irwrite  in  1  from controller: load the IR from memdata.
- regwrite_in  in  1  from controller: register-file write request.
- wb_data  in  WIDTH  value being written back to the register file.
- alu_carry  in  1  carry-out of the ALU result being written back.
- op  out  4  instr[15:12].
- cz  out  2  instr[1:0].
- ra, rb, rc  out  3 each  instr[11:9], instr[8:6], instr[5:3].
- imm6_se  out  WIDTH  instr[5:0], sign-extended.
- imm9_se  out  WIDTH  instr[8:0], sign-extended.
- regwrite  out  1  gated register-file write enable.
- cond_ok  out  1  current instruction passes its C/Z condition.
- c_flag, z_flag  out  1 each  architectural flags.
- retired  out  CNT_W  count of instructions loaded into the IR.

Behaviour:
- Reset (reset=0, async), all state cleared:
  - IR = 16'h0000, so op=0 and cz=0.
  - C = 0, Z = 0.
  - retired = 0.
  - All field outputs are therefore 0.
  - regwrite = 0 while reset is low, independent of regwrite_in.
- IR load:
  - When irwrite=1 at a rising edge, the IR takes memdata.
  - All decoded fields are combinational from the IR and become valid the cycle after the load edge.
  - When irwrite=0, the IR holds its value.
- Retired counter:
  - Increments by 1 on every edge where irwrite=1.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- cond_ok is combinational from the IR and the current flags:
  - op=0000 (ADD family): cz=00 gives 1; cz=10 (ADC) gives C; cz=01 (ADZ) gives Z; cz=11 gives 1.
  - op=0010 (NAND family): cz=00 gives 1; cz=10 (NDC) gives C; cz=01 (NDZ) gives Z; cz=11 is reserved and gives 0.
  - Any other op gives 1.
- regwrite = regwrite_in AND cond_ok AND reset. There is no added latency.
- Flag update occurs only on an edge where the gated regwrite=1, decoding the IR held at that edge:
  - ADD family (0000): C takes alu_carry; Z takes (wb_data==0).
  - ADI (0001): C takes alu_carry; Z takes (wb_data==0).
  - NAND family (0010): Z takes (wb_data==0); C holds.
  - LW (0100): Z takes (wb_data==0); C holds.
  - All other ops: both flags hold.
- Suppressed writes: when cond_ok=0, neither the register file nor the flags change. The controller proceeds to fetch as normal.
- Simultaneous events:
  - irwrite and a gated regwrite on the same edge: the flag update uses the old IR contents; the IR loads the new instruction on that same edge.
  - A flag update and a cond_ok evaluation in the same instruction: cond_ok uses the pre-update flags, because flags change only at the edge.
- Reset mid-instruction: the IR, flags and counter clear immediately (asynchronously). regwrite drops in the same cycle. No partial flag update survives.

Test Plan:
- Reset behaviour: hold reset=0, pulse irwrite with memdata=16'hFFFF and drive regwrite_in=1 -> IR=0, regwrite=0, C=Z=0, retired=0 throughout. Release reset -> the next irwrite loads the IR.
- Field decode: load 16'b0001_011_101_110010 (ADI) -> op=1, ra=3, rb=5, imm6_se=16'hFFF2, retired=1.
- ADD sets flags: load ADD (cz=00), then regwrite_in=1, wb_data=0, alu_carry=1 -> regwrite=1, and after the edge C=1, Z=1.
- ADC taken and not taken:
  - With C=1, load 0000_001_001_000_10 and assert regwrite_in -> regwrite=1.
  - Clear C via ADD with alu_carry=0 and wb_data=5, reload the ADC -> regwrite=0 and the flags are unchanged.
- NDZ / NAND cz=11:
  - With Z=0, NDZ (0010_...._01) gives regwrite=0.
  - With Z=1, NDZ gives regwrite=1, and after wb_data=16'h0004 the result is Z=0 with C unchanged.
  - cz=11 NAND always gives regwrite=0.
- Same-edge irwrite and writeback:
  - ADD is in the IR; assert irwrite (memdata = LW) together with regwrite_in=1, wb_data=0 -> Z=1 per the ADD rule, IR=LW, retired increments by 1.
  - Additionally, preset retired to 16'hFFFF by loading the IR 65535 times beforehand -> retired wraps to 0 on that edge.
